// File: rtl/cnn_conv_core.sv
// Valid-mode KxK convolution engine: loads a signed kernel, then produces one
// output pixel every K*K+2 cycles from synchronous image/kernel buffers.
module cnn_conv_core #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int OUT_W = 32,
  localparam int IA_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  localparam int KA_W = (K * K > 1) ? $clog2(K * K) : 1,
  localparam int RA_W = ((IMG_W - K + 1) * (IMG_H - K + 1) > 1) ?
                        $clog2((IMG_W - K + 1) * (IMG_H - K + 1)) : 1
) (
  input  logic             s00_axi_aclk,
  input  logic             s00_axi_aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic             stride2,
  input  logic             relu_en,
  output logic             busy,
  output logic             done,
  output logic [IA_W-1:0]  img_addr,
  input  logic [DW-1:0]    img_rdata,
  output logic [KA_W-1:0]  ker_addr,
  input  logic [WW-1:0]    ker_rdata,
  output logic             res_we,
  output logic [RA_W-1:0]  res_addr,
  output logic [OUT_W-1:0] res_wdata
);

  localparam int KK    = K * K;
  localparam int CNT_W = $clog2(KK + 1);
  localparam int ACC_W = DW + WW + $clog2(KK) + 1;
  localparam int XW    = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
  localparam int OW1   = IMG_W - K + 1;
  localparam int OH1   = IMG_H - K + 1;
  localparam int OW2   = (IMG_W - K) / 2 + 1;
  localparam int OH2   = (IMG_H - K) / 2 + 1;

  generate
    if (K < 1 || K > IMG_W || K > IMG_H) begin : g_bad_k
      $error("cnn_conv_core: K must satisfy 1 <= K <= IMG_W and K <= IMG_H");
    end
    if (DW + WW + $clog2(K * K) + 1 > OUT_W) begin : g_bad_out_w
      $error("cnn_conv_core: accumulator width exceeds OUT_W");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    MAC    = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [XW-1:0]           kx_r, ky_r, ox_r, oy_r;
  logic [RA_W-1:0]         res_cnt_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    s2_r, relu_r;
  logic [WW-1:0]           w_r [KK];

  logic [KA_W-1:0]          widx_s;
  logic signed [ACC_W-1:0]  prod_s, acc_sum_s;
  logic signed [OUT_W-1:0]  acc_ext_s;
  logic [OUT_W-1:0]         res_val_s;
  logic [XW-1:0]            kx_nxt_s, ky_nxt_s, ox_nxt_s, oy_nxt_s;
  logic [XW-1:0]            ow_last_s, oh_last_s;
  logic                     last_col_s, last_row_s;

  function automatic logic [IA_W-1:0] pix_addr(input logic [XW-1:0] ox,
                                               input logic [XW-1:0] oy,
                                               input logic [XW-1:0] kx,
                                               input logic [XW-1:0] ky,
                                               input logic          s2);
    int row, col;
    row = int'(s2 ? {oy, 1'b0} : {1'b0, oy}) + int'(ky);
    col = int'(s2 ? {ox, 1'b0} : {1'b0, ox}) + int'(kx);
    return IA_W'(row * IMG_W + col);
  endfunction

  // Tap/pixel successors and the accumulator update for the data returning this cycle.
  always_comb begin
    // Weight index lags the issue counter by one because of the buffer latency.
    widx_s    = KA_W'(cnt_r - CNT_W'(1));
    prod_s    = $signed({{(ACC_W - DW){1'b0}}, img_rdata}) *
                $signed({{(ACC_W - WW){w_r[widx_s][WW-1]}}, w_r[widx_s]});
    acc_sum_s = acc_r + prod_s;
    acc_ext_s = OUT_W'(acc_sum_s);
    if (relu_r && acc_sum_s[ACC_W-1]) begin
      res_val_s = {OUT_W{1'b0}};
    end else begin
      res_val_s = acc_ext_s;
    end
    if (kx_r == XW'(K - 1)) begin
      kx_nxt_s = {XW{1'b0}};
      ky_nxt_s = ky_r + XW'(1);
    end else begin
      kx_nxt_s = kx_r + XW'(1);
      ky_nxt_s = ky_r;
    end
    ow_last_s  = s2_r ? XW'(OW2 - 1) : XW'(OW1 - 1);
    oh_last_s  = s2_r ? XW'(OH2 - 1) : XW'(OH1 - 1);
    last_col_s = (ox_r == ow_last_s);
    last_row_s = (oy_r == oh_last_s);
    if (last_col_s) begin
      ox_nxt_s = {XW{1'b0}};
      oy_nxt_s = oy_r + XW'(1);
    end else begin
      ox_nxt_s = ox_r + XW'(1);
      oy_nxt_s = oy_r;
    end
  end

  // Control FSM, address generation, weight capture and registered outputs.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_we    <= 1'b0;
      img_addr  <= {IA_W{1'b0}};
      ker_addr  <= {KA_W{1'b0}};
      res_addr  <= {RA_W{1'b0}};
      res_wdata <= {OUT_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      kx_r      <= {XW{1'b0}};
      ky_r      <= {XW{1'b0}};
      ox_r      <= {XW{1'b0}};
      oy_r      <= {XW{1'b0}};
      res_cnt_r <= {RA_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      s2_r      <= 1'b0;
      relu_r    <= 1'b0;
      for (int i = 0; i < KK; i++) w_r[i] <= {WW{1'b0}};
    end else if (abort) begin
      // Abort has the same effect as reset, including dropping the weights.
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      res_we    <= 1'b0;
      img_addr  <= {IA_W{1'b0}};
      ker_addr  <= {KA_W{1'b0}};
      res_addr  <= {RA_W{1'b0}};
      res_wdata <= {OUT_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      kx_r      <= {XW{1'b0}};
      ky_r      <= {XW{1'b0}};
      ox_r      <= {XW{1'b0}};
      oy_r      <= {XW{1'b0}};
      res_cnt_r <= {RA_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      s2_r      <= 1'b0;
      relu_r    <= 1'b0;
      for (int i = 0; i < KK; i++) w_r[i] <= {WW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done   <= 1'b0;
          res_we <= 1'b0;
          if (start) begin
            state_r   <= LOAD_K;
            busy      <= 1'b1;
            s2_r      <= stride2;
            relu_r    <= relu_en;
            cnt_r     <= {CNT_W{1'b0}};
            ker_addr  <= {KA_W{1'b0}};
            res_cnt_r <= {RA_W{1'b0}};
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD_K: begin
          if (cnt_r != {CNT_W{1'b0}}) w_r[widx_s] <= ker_rdata;
          if (cnt_r == CNT_W'(KK)) begin
            state_r  <= MAC;
            cnt_r    <= {CNT_W{1'b0}};
            kx_r     <= {XW{1'b0}};
            ky_r     <= {XW{1'b0}};
            ox_r     <= {XW{1'b0}};
            oy_r     <= {XW{1'b0}};
            acc_r    <= {ACC_W{1'b0}};
            img_addr <= {IA_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r < CNT_W'(KK - 1)) ker_addr <= KA_W'(cnt_r + CNT_W'(1));
          end
        end
        MAC: begin
          if (cnt_r != {CNT_W{1'b0}}) acc_r <= acc_sum_s;
          if (cnt_r == CNT_W'(KK)) begin
            state_r   <= WRITE;
            res_we    <= 1'b1;
            res_addr  <= res_cnt_r;
            res_wdata <= res_val_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r < CNT_W'(KK - 1)) begin
              kx_r     <= kx_nxt_s;
              ky_r     <= ky_nxt_s;
              img_addr <= pix_addr(ox_r, oy_r, kx_nxt_s, ky_nxt_s, s2_r);
            end
          end
        end
        WRITE: begin
          res_we    <= 1'b0;
          res_cnt_r <= res_cnt_r + RA_W'(1);
          cnt_r     <= {CNT_W{1'b0}};
          kx_r      <= {XW{1'b0}};
          ky_r      <= {XW{1'b0}};
          acc_r     <= {ACC_W{1'b0}};
          if (last_col_s && last_row_s) begin
            state_r <= DONE;
            done    <= 1'b1;
          end else begin
            state_r  <= MAC;
            ox_r     <= ox_nxt_s;
            oy_r     <= oy_nxt_s;
            img_addr <= pix_addr(ox_nxt_s, oy_nxt_s, {XW{1'b0}}, {XW{1'b0}}, s2_r);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          res_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_conv_core.sv
// Directed self-checking bench for cnn_conv_core with default parameters
// (32x32 image, 5x5 kernel, 8-bit data, 32-bit results).
module tb_cnn_conv_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, stride2, relu_en;
  logic        busy, done, res_we;
  logic [9:0]  img_addr;
  logic [7:0]  img_rdata;
  logic [4:0]  ker_addr;
  logic [7:0]  ker_rdata;
  logic [9:0]  res_addr;
  logic [31:0] res_wdata;

  logic [7:0]  img_mem [0:1023];
  logic [7:0]  ker_mem [0:24];

  int n_vec = 0;
  int n_err = 0;
  int tick = 0;
  int e0 = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_mode = 0;
  int saved_wr;

  always #5 clk = ~clk;

  cnn_conv_core dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .start           (start),
    .abort           (abort),
    .stride2         (stride2),
    .relu_en         (relu_en),
    .busy            (busy),
    .done            (done),
    .img_addr        (img_addr),
    .img_rdata       (img_rdata),
    .ker_addr        (ker_addr),
    .ker_rdata       (ker_rdata),
    .res_we          (res_we),
    .res_addr        (res_addr),
    .res_wdata       (res_wdata)
  );

  // Synchronous buffers: data for an address appears one cycle later.
  always @(posedge clk) begin
    img_rdata <= img_mem[img_addr];
    ker_rdata <= ker_mem[ker_addr];
  end

  // Free-running edge counter used for cycle-exact timing checks.
  always @(posedge clk) tick <= tick + 1;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", tag, got, got, want, want);
    end
  endtask

  // Hand-computed result per scenario; idx is the row-major output index.
  function automatic logic [31:0] exp_val(input int idx);
    case (exp_mode)
      0:       return 32'd325;             // sum of 1..25 over an all-ones image
      1:       return 32'(2 * (idx % 14)); // stride 2 picks p[2oy][2ox] = 2*ox
      2:       return 32'hFFF38C80;        // 255 * -128 * 25 = -816000
      default: return 32'd0;               // ReLU clamps the negative sum
    endcase
  endfunction

  // Result-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_we) begin
        if (wr_cnt == 0) chk_val("first_we_cycle", 32'(tick - e0 + 1), 32'd53);
        chk_val("res_addr", 32'(res_addr), 32'(wr_cnt));
        chk_val("res_wdata", res_wdata, exp_val(wr_cnt));
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = tick - e0 + 1;
      end
    end
  end

  task automatic reset_checks(input string pfx);
    chk_val({pfx, "_busy"},      32'(busy),      32'd0);
    chk_val({pfx, "_done"},      32'(done),      32'd0);
    chk_val({pfx, "_res_we"},    32'(res_we),    32'd0);
    chk_val({pfx, "_img_addr"},  32'(img_addr),  32'd0);
    chk_val({pfx, "_ker_addr"},  32'(ker_addr),  32'd0);
    chk_val({pfx, "_res_addr"},  32'(res_addr),  32'd0);
    chk_val({pfx, "_res_wdata"}, res_wdata,      32'd0);
  endtask

  task automatic start_run(input logic s2, input logic relu);
    wr_cnt   = 0;
    done_cnt = 0;
    done_cyc = 0;
    stride2  = s2;
    relu_en  = relu;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = tick;
    // Mode inputs must be latched at start, so flip them for the rest of the run.
    stride2 = ~s2;
    relu_en = ~relu;
    chk_val("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget, input logic pulse);
    for (int c = 0; c < budget && done_cnt == 0; c++) begin
      @(negedge clk);
      start = (pulse && done_cnt == 0 && (c % 10) == 9) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic end_checks(input int exp_wr, input int exp_cyc);
    chk_val("done_count",  32'(done_cnt), 32'd1);
    chk_val("write_count", 32'(wr_cnt),   32'(exp_wr));
    chk_val("done_cycle",  32'(done_cyc), 32'(exp_cyc));
    chk_val("idle_busy",   32'(busy),     32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    stride2 = 1'b0;
    relu_en = 1'b0;
    for (int i = 0; i < 1024; i++) img_mem[i] = 8'd1;
    for (int i = 0; i < 25; i++) ker_mem[i] = 8'(i + 1);
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-MAC at cycle 100, after two writes have landed.
    exp_mode = 0;
    start_run(1'b0, 1'b0);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1 again, with start pulsed every 10 cycles during the run.
    start_run(1'b0, 1'b0);
    wait_done(22000, 1'b1);
    end_checks(784, 21195);

    // Abort at cycle 1000, then a fresh full run with relu off.
    for (int i = 0; i < 1024; i++) img_mem[i] = 8'd255;
    for (int i = 0; i < 25; i++) ker_mem[i] = 8'h80;
    exp_mode = 2;
    start_run(1'b0, 1'b0);
    repeat (999) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_val("abort_busy", 32'(busy), 32'd0);
    chk_val("abort_we", 32'(res_we), 32'd0);
    saved_wr = wr_cnt;
    chk_val("abort_writes_before", 32'(saved_wr), 32'd36);
    repeat (200) @(negedge clk);
    chk_val("abort_writes_after", 32'(wr_cnt), 32'(saved_wr));
    chk_val("abort_no_done", 32'(done_cnt), 32'd0);
    start_run(1'b0, 1'b0);
    wait_done(22000, 1'b0);
    end_checks(784, 21195);

    // Same data with ReLU on, stride 2.
    exp_mode = 3;
    start_run(1'b1, 1'b1);
    wait_done(6000, 1'b0);
    end_checks(196, 5319);

    // Column ramp image, single-tap kernel, stride 2.
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) img_mem[y * 32 + x] = 8'(x);
    for (int i = 0; i < 25; i++) ker_mem[i] = 8'd0;
    ker_mem[0] = 8'd1;
    exp_mode = 1;
    start_run(1'b1, 1'b0);
    wait_done(6000, 1'b0);
    end_checks(196, 5319);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
